// File: rtl/hazard_control_unit_if.sv
// Signal bundle between the pipeline datapath and the hazard control unit.
// The master drives the hazard inputs; the slave (controller) drives the enables and flushes.
interface hazard_control_unit_if;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        mem_branch_taken;
    logic        mem_req;
    logic        mem_ready;

    logic        pc_write;
    logic        ifid_write;
    logic        idex_write;
    logic        exmem_write;
    logic        ifid_flush;
    logic        idex_flush;
    logic        exmem_flush;
    logic        idex_bubble;
    logic        memwb_bubble;
    logic [1:0]  ctrl_state;
    logic        mem_error;
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
               mem_branch_taken, mem_req, mem_ready,
        input  pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush,
               exmem_flush, idex_bubble, memwb_bubble, ctrl_state, mem_error,
               stall_cycles, flush_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
               mem_branch_taken, mem_req, mem_ready,
        output pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush,
               exmem_flush, idex_bubble, memwb_bubble, ctrl_state, mem_error,
               stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes, memory-wait freeze
// with timeout to HALT, plus saturating stall/flush counters.
module hazard_control_unit #(
    parameter int unsigned ZERO_REG        = 31,
    parameter int unsigned LOAD_USE_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT     = 255
) (
    input logic                  clk,
    input logic                  rst,
    hazard_control_unit_if.slave ctrl_io
);

    localparam logic [4:0]  ZeroReg    = 5'(ZERO_REG);
    localparam logic [2:0]  LuReload   = 3'(LOAD_USE_CYCLES - 1);
    localparam logic [16:0] TimeoutLim = 17'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        StRun       = 2'd0,
        StLoadStall = 2'd1,
        StMemWait   = 2'd2,
        StHalt      = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  lu_cnt_q, lu_cnt_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_q, stall_d;
    logic [15:0] flush_q, flush_d;
    logic [16:0] wait_next;

    logic hz_mem, hz_lu;
    logic pc_write, ifid_write, idex_write, exmem_write;
    logic ifid_flush, idex_flush, exmem_flush, idex_bubble, memwb_bubble, mem_error;

    assign hz_mem = ctrl_io.mem_req & ~ctrl_io.mem_ready;
    assign hz_lu  = ctrl_io.id_valid & ctrl_io.ex_mem_read & (ctrl_io.ex_rd != ZeroReg) &
                    ((ctrl_io.id_rs1_used & (ctrl_io.id_rs1 == ctrl_io.ex_rd)) |
                     (ctrl_io.id_rs2_used & (ctrl_io.id_rs2 == ctrl_io.ex_rd)));

    // Wait count including the current not-ready cycle.
    assign wait_next = (state_q == StMemWait) ? {1'b0, wait_cnt_q} + 17'd1 : 17'd1;

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        exmem_write  = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        idex_bubble  = 1'b0;
        memwb_bubble = 1'b0;
        mem_error    = 1'b0;
        state_d      = state_q;
        lu_cnt_d     = lu_cnt_q;
        wait_cnt_d   = wait_cnt_q;

        if (state_q == StHalt) begin
            {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
            mem_error = 1'b1;
        end else if (hz_mem) begin
            {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
            memwb_bubble = 1'b1;
            wait_cnt_d   = wait_next[15:0];
            state_d      = (wait_next >= TimeoutLim) ? StHalt : StMemWait;
        end else if (ctrl_io.mem_branch_taken) begin
            {ifid_flush, idex_flush, exmem_flush} = 3'b111;
            state_d = StRun;
        end else if (state_q == StLoadStall || hz_lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            if (state_q == StLoadStall) begin
                lu_cnt_d = lu_cnt_q - 3'd1;
                state_d  = (lu_cnt_q == 3'd1) ? StRun : StLoadStall;
            end else if (LOAD_USE_CYCLES > 1) begin
                lu_cnt_d = LuReload;
                state_d  = StLoadStall;
            end else begin
                state_d = StRun;
            end
        end else begin
            state_d = StRun;
        end

        // Reset forces the pipeline registers to clear regardless of state.
        if (rst) begin
            {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
            {ifid_flush, idex_flush, exmem_flush}           = 3'b111;
            idex_bubble  = 1'b0;
            memwb_bubble = 1'b0;
            mem_error    = 1'b0;
        end
    end

    assign stall_d = (!pc_write && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    assign flush_d = (exmem_flush && flush_q != 16'hFFFF) ? flush_q + 16'd1 : flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRun;
            lu_cnt_q   <= 3'd0;
            wait_cnt_q <= 16'd0;
            stall_q    <= 16'd0;
            flush_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            lu_cnt_q   <= lu_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
        end
    end

    assign ctrl_io.pc_write     = pc_write;
    assign ctrl_io.ifid_write   = ifid_write;
    assign ctrl_io.idex_write   = idex_write;
    assign ctrl_io.exmem_write  = exmem_write;
    assign ctrl_io.ifid_flush   = ifid_flush;
    assign ctrl_io.idex_flush   = idex_flush;
    assign ctrl_io.exmem_flush  = exmem_flush;
    assign ctrl_io.idex_bubble  = idex_bubble;
    assign ctrl_io.memwb_bubble = memwb_bubble;
    assign ctrl_io.mem_error    = mem_error;
    assign ctrl_io.ctrl_state   = state_q;
    assign ctrl_io.stall_cycles = stall_q;
    assign ctrl_io.flush_count  = flush_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: two instances (1-cycle/timeout 8 and 3-cycle/timeout 65535)
// share directed stimulus and are checked every cycle against a behavioural model.
module tb_hazard_control_unit;

    typedef struct packed {
        logic pc_write, ifid_write, idex_write, exmem_write;
        logic ifid_flush, idex_flush, exmem_flush;
        logic idex_bubble, memwb_bubble, mem_error;
    } exp_t;

    // mode: 0 run, 1 load stall, 2 memory wait, 3 halt
    typedef struct {
        int mode;
        int rem;
        int waited;
        int stalls;
        int flushes;
    } mdl_t;

    logic       clk, rst;
    logic       id_valid, id_rs1_used, id_rs2_used, ex_mem_read;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       mem_branch_taken, mem_req, mem_ready;

    int n_checks = 0;
    int n_errors = 0;

    string onames [10] = '{"pc_write", "ifid_write", "idex_write", "exmem_write", "ifid_flush",
                           "idex_flush", "exmem_flush", "idex_bubble", "memwb_bubble",
                           "mem_error"};

    hazard_control_unit_if if1 ();
    hazard_control_unit_if if3 ();

    assign if1.id_valid = id_valid;  assign if1.id_rs1 = id_rs1;  assign if1.id_rs2 = id_rs2;
    assign if1.id_rs1_used = id_rs1_used;  assign if1.id_rs2_used = id_rs2_used;
    assign if1.ex_rd = ex_rd;  assign if1.ex_mem_read = ex_mem_read;
    assign if1.mem_branch_taken = mem_branch_taken;
    assign if1.mem_req = mem_req;  assign if1.mem_ready = mem_ready;

    assign if3.id_valid = id_valid;  assign if3.id_rs1 = id_rs1;  assign if3.id_rs2 = id_rs2;
    assign if3.id_rs1_used = id_rs1_used;  assign if3.id_rs2_used = id_rs2_used;
    assign if3.ex_rd = ex_rd;  assign if3.ex_mem_read = ex_mem_read;
    assign if3.mem_branch_taken = mem_branch_taken;
    assign if3.mem_req = mem_req;  assign if3.mem_ready = mem_ready;

    hazard_control_unit #(.ZERO_REG(31), .LOAD_USE_CYCLES(1), .MEM_TIMEOUT(8)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .ctrl_io (if1)
    );

    hazard_control_unit #(.ZERO_REG(31), .LOAD_USE_CYCLES(3), .MEM_TIMEOUT(65535)) dut3 (
        .clk     (clk),
        .rst     (rst),
        .ctrl_io (if3)
    );

    exp_t act1, act3;
    assign act1 = {if1.pc_write, if1.ifid_write, if1.idex_write, if1.exmem_write,
                   if1.ifid_flush, if1.idex_flush, if1.exmem_flush, if1.idex_bubble,
                   if1.memwb_bubble, if1.mem_error};
    assign act3 = {if3.pc_write, if3.ifid_write, if3.idex_write, if3.exmem_write,
                   if3.ifid_flush, if3.idex_flush, if3.exmem_flush, if3.idex_bubble,
                   if3.memwb_bubble, if3.mem_error};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected outputs this cycle and model state after the next edge.
    function automatic void mstep(input int lu, input int to, input mdl_t m,
                                  output exp_t e, output mdl_t n);
        bit hzm, hzl;
        n = m;
        e = 10'b1111000000;
        if (rst) begin
            e = 10'b0000111000;
            n = '{0, 0, 0, 0, 0};
            return;
        end
        hzm = mem_req && !mem_ready;
        hzl = id_valid && ex_mem_read && ex_rd != 5'd31 &&
              ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
        if (m.mode == 3) begin
            e = 10'b0000000001;
        end else if (hzm) begin
            e = 10'b0000000010;
            n.waited = (m.mode == 2) ? m.waited + 1 : 1;
            n.mode   = (n.waited >= to) ? 3 : 2;
        end else if (mem_branch_taken) begin
            e.ifid_flush  = 1'b1;
            e.idex_flush  = 1'b1;
            e.exmem_flush = 1'b1;
            n.mode = 0;
        end else if (m.mode == 1 || hzl) begin
            e.pc_write    = 1'b0;
            e.ifid_write  = 1'b0;
            e.idex_bubble = 1'b1;
            n.rem  = (m.mode == 1) ? m.rem - 1 : lu - 1;
            n.mode = (n.rem > 0) ? 1 : 0;
        end else begin
            n.mode = 0;
        end
        if (!e.pc_write)   n.stalls  = (m.stalls  < 65535) ? m.stalls  + 1 : 65535;
        if (e.exmem_flush) n.flushes = (m.flushes < 65535) ? m.flushes + 1 : 65535;
    endfunction

    task automatic cmp_dut(input string tag, input exp_t act, input exp_t e, input bit valid,
                           input logic [1:0] st, input logic [15:0] sc, input logic [15:0] fc,
                           input mdl_t m);
        for (int i = 0; i < 10; i++) chk({tag, ".", onames[i]}, int'(act[9-i]), int'(e[9-i]));
        if (valid) begin
            chk({tag, ".ctrl_state"}, int'(st), m.mode);
            chk({tag, ".stall_cycles"}, int'(sc), m.stalls);
            chk({tag, ".flush_count"}, int'(fc), m.flushes);
        end
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        mdl_t m1, m3, n1, n3;
        exp_t e1, e3;
        bit   valid;
        m1 = '{0, 0, 0, 0, 0};
        m3 = '{0, 0, 0, 0, 0};
        valid = 1'b0;
        forever begin
            @(negedge clk);
            mstep(1, 8, m1, e1, n1);
            mstep(3, 65535, m3, e3, n3);
            cmp_dut("d1", act1, e1, valid, if1.ctrl_state, if1.stall_cycles, if1.flush_count, m1);
            cmp_dut("d3", act3, e3, valid, if3.ctrl_state, if3.stall_cycles, if3.flush_count, m3);
            @(posedge clk);
            m1 = n1;
            m3 = n3;
            if (rst) valid = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0;  id_rs1 = 5'd0;  id_rs2 = 5'd0;  id_rs1_used = 1'b0;
        id_rs2_used = 1'b0;  ex_rd = 5'd0;  ex_mem_read = 1'b0;
        mem_branch_taken = 1'b0;  mem_req = 1'b0;  mem_ready = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] rd);
        id_valid = 1'b1;  ex_mem_read = 1'b1;  ex_rd = rd;
        id_rs2 = 5'd2;  id_rs2_used = 1'b1;  id_rs1 = 5'd7;  id_rs1_used = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        @(negedge clk);
        chk("rst_pc_write", int'(if1.pc_write), 0);
        chk("rst_ifid_flush", int'(if1.ifid_flush), 1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_state", int'(if1.ctrl_state), 0);
        chk("post_rst_stalls", int'(if3.stall_cycles), 0);
        chk("post_rst_pc_write", int'(if1.pc_write), 1);
        tick();

        // Load-use on rs2: one stall cycle for dut1, three for dut3.
        load_use(5'd2);
        @(negedge clk);
        chk("lu_d1_bubble", int'(if1.idex_bubble), 1);
        chk("lu_d1_pc_write", int'(if1.pc_write), 0);
        chk("lu_d3_state_a", int'(if3.ctrl_state), 0);
        tick();
        idle();
        @(negedge clk);
        chk("lu_d3_state_b", int'(if3.ctrl_state), 1);
        tick();
        @(negedge clk);
        chk("lu_d3_state_c", int'(if3.ctrl_state), 1);
        tick();
        @(negedge clk);
        chk("lu_d3_state_d", int'(if3.ctrl_state), 0);
        chk("lu_d1_stalls", int'(if1.stall_cycles), 1);
        chk("lu_d3_stalls", int'(if3.stall_cycles), 3);
        tick();

        // Destination XZR never stalls.
        load_use(5'd31);
        id_rs2 = 5'd31;
        @(negedge clk);
        chk("xzr_d1_pc_write", int'(if1.pc_write), 1);
        chk("xzr_d3_bubble", int'(if3.idex_bubble), 0);
        tick();
        idle();

        // Branch in the second stall cycle squashes the remaining load stall.
        load_use(5'd2);
        tick();
        idle();
        mem_branch_taken = 1'b1;
        @(negedge clk);
        chk("br_d3_state", int'(if3.ctrl_state), 1);
        chk("br_d3_exmem_flush", int'(if3.exmem_flush), 1);
        tick();
        idle();
        @(negedge clk);
        chk("br_d3_state_after", int'(if3.ctrl_state), 0);
        chk("br_d3_flushes", int'(if3.flush_count), 1);
        chk("br_d3_stalls", int'(if3.stall_cycles), 4);
        tick();

        // Four not-ready cycles with a pending branch, then ready.
        mem_req = 1'b1;
        mem_branch_taken = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 2) begin
                chk("mw_d1_state", int'(if1.ctrl_state), 2);
                chk("mw_d1_memwb_bubble", int'(if1.memwb_bubble), 1);
                chk("mw_d1_no_flush", int'(if1.exmem_flush), 0);
            end
            tick();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk("mw_ready_flush", int'(if1.exmem_flush), 1);
        chk("mw_ready_pc_write", int'(if3.pc_write), 1);
        tick();
        idle();
        @(negedge clk);
        chk("mw_d1_stalls", int'(if1.stall_cycles), 6);
        chk("mw_d3_stalls", int'(if3.stall_cycles), 8);
        chk("mw_d1_flushes", int'(if1.flush_count), 2);
        chk("mw_d1_state_after", int'(if1.ctrl_state), 0);
        tick();

        // Timeout of 8 on dut1: HALT exactly after the 8th not-ready cycle.
        mem_req = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 8) chk("to_d1_state_c8", int'(if1.ctrl_state), 2);
            if (c == 9) begin
                chk("to_d1_state_c9", int'(if1.ctrl_state), 3);
                chk("to_d1_mem_error", int'(if1.mem_error), 1);
            end
            tick();
        end
        idle();
        tick();
        @(negedge clk);
        chk("halt_d1_state", int'(if1.ctrl_state), 3);
        chk("halt_d1_pc_write", int'(if1.pc_write), 0);
        chk("halt_d3_state", int'(if3.ctrl_state), 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("halt_rst_state", int'(if1.ctrl_state), 0);
        chk("halt_rst_mem_error", int'(if1.mem_error), 0);
        chk("halt_rst_stalls", int'(if1.stall_cycles), 0);
        tick();

        // Long wait: dut3 halts at 65535 and both stall counters saturate.
        mem_req = 1'b1;
        repeat (65545) tick();
        @(negedge clk);
        chk("sat_d3_state", int'(if3.ctrl_state), 3);
        chk("sat_d3_stalls", int'(if3.stall_cycles), 65535);
        chk("sat_d1_stalls", int'(if1.stall_cycles), 65535);
        tick();
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline sequencing controller for the 64-bit 5-stage core. Sits beside `forwardingUnit` in the pipeline. It handles the hazards that forwarding cannot resolve:
- load-use stalls, with bubble insertion into EX;
- taken-branch flushes resolved in MEM;
- whole-pipeline freeze while a MEM-stage memory access waits on `mem_ready`, with a timeout to a HALT state.

It drives the pipeline-register write enables, flushes and bubbles, and keeps saturating performance counters.

## Interface
Parameters:
- `ZERO_REG`, 31: register index that never creates a hazard (XZR).
- `LOAD_USE_CYCLES`, 1: stall length per load-use hazard. Legal range 1..7.
- `MEM_TIMEOUT`, 255: maximum consecutive `MEM_WAIT` cycles before HALT. Legal range 1..65535.

Ports:
- `clk` in 1: rising-edge clock. This is the only clock.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs1`, `id_rs2` in 5 each: ID source registers.
- `id_rs1_used`, `id_rs2_used` in 1 each: the matching source is actually read.
- `ex_rd` in 5: EX destination register.
- `ex_mem_read` in 1: EX instruction is a load.
- `mem_branch_taken` in 1: MEM stage resolved a taken branch this cycle.
- `mem_req` in 1: MEM stage is issuing a data-memory access.
- `mem_ready` in 1: data memory completes the access this cycle.
- `pc_write`, `ifid_write`, `idex_write`, `exmem_write` out 1 each: register load enables.
- `ifid_flush`, `idex_flush`, `exmem_flush` out 1 each: clear the register to a NOP on the next edge.
- `idex_bubble` out 1: load a NOP into ID/EX instead of the ID contents.
- `memwb_bubble` out 1: load a NOP into MEM/WB.
- `ctrl_state` out 2: 0 = RUN, 1 = LOAD_STALL, 2 = MEM_WAIT, 3 = HALT.
- `mem_error` out 1: high iff the state is HALT.
- `stall_cycles` out 16: saturating count of cycles with `pc_write` = 0 after reset.
- `flush_count` out 16: saturating count of taken-branch flushes.

## Operation
Hazard conditions:
- **hz_mem** = `mem_req & ~mem_ready`.
- **hz_lu** = `id_valid & ex_mem_read & (ex_rd != ZERO_REG) & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd))`.
- Priority is **hz_mem** > `mem_branch_taken` > **hz_lu**.

Output defaults: all write enables = 1, all flush and bubble outputs = 0.

Per-state behavior (outputs are combinational from state and inputs):
- **RUN**
  - **hz_mem**: all four write enables = 0, `memwb_bubble` = 1. Next state MEM_WAIT with wait counter = 1.
  - `mem_branch_taken`: `ifid_flush`, `idex_flush`, `exmem_flush` = 1. `pc_write` = 1 so PC loads the target. State stays RUN.
  - **hz_lu**: `pc_write` = 0, `ifid_write` = 0, `idex_bubble` = 1. If `LOAD_USE_CYCLES` > 1, next state LOAD_STALL with the remaining counter = `LOAD_USE_CYCLES` − 1. Otherwise stay in RUN.
- **LOAD_STALL**
  - Drives the same outputs as **hz_lu** and decrements the counter.
  - Returns to RUN when the counter reaches 0.
  - **hz_mem** overrides: MEM_WAIT outputs and transition. The remaining stall is discarded; **hz_lu** is re-evaluated after the wait.
  - `mem_branch_taken` overrides: flush outputs and next state RUN, because the load is squashed.
- **MEM_WAIT**
  - Outputs held as for **hz_mem** while **hz_mem** is true; wait counter increments.
  - On `mem_ready` (or `mem_req` dropping): outputs are evaluated exactly as in RUN for that cycle, and next state is RUN.
  - If the wait counter reaches `MEM_TIMEOUT` while **hz_mem** is still true: next state HALT.
- **HALT**
  - All write enables = 0, flush and bubble outputs = 0, `mem_error` = 1.
  - Exits only through `rst`.

Counters:
- Saturate at 0xFFFF.
- `stall_cycles` counts every cycle with `pc_write` = 0 outside reset, including HALT.
- `flush_count` counts each cycle in which `exmem_flush` = 1.

## Timing
Reset:
- While `rst` = 1, outputs are forced: all write enables = 0, all flush outputs = 1, bubbles = 0, `mem_error` = 0.
- After the edge with `rst` = 1: `ctrl_state` = RUN, all counters = 0, `stall_cycles` = `flush_count` = 0.
- Reset in any state, including HALT or mid LOAD_STALL, takes effect at that edge.

Latency and handshake:
- Hazard outputs respond to inputs in the same cycle (zero latency). State and counters update on the rising edge.
- Memory handshake completes in the cycle where `mem_req` & `mem_ready` are both 1. If `mem_ready` is high in the first request cycle, there is no stall.

Stall lengths:
- A load-use hazard removes exactly `LOAD_USE_CYCLES` cycles of PC advance.
- A memory wait of N not-ready cycles freezes the pipeline for N cycles.

Simultaneous events and boundaries:
- **hz_mem** with a branch or **hz_lu** in the same cycle: only **hz_mem** is acted on. The others are re-evaluated once the access completes.
- `ex_rd` = `ZERO_REG` never stalls.
- The timeout fires at exactly `MEM_TIMEOUT` consecutive wait cycles, not one more.

## Test plan
- **Reset:** `rst` high 2 cycles → forced values during reset (enables 0, flushes 1). Afterwards `ctrl_state` = 0, counters = 0, all enables 1.
- **Load-use:** `ex_mem_read` = 1, `ex_rd` = 2, `id_rs2` = 2, `id_rs2_used` = 1, `LOAD_USE_CYCLES` = 1 → one cycle of `pc_write` = 0, `ifid_write` = 0, `idex_bubble` = 1; `stall_cycles` = 1.
  - Same stimulus with `ex_rd` = 31 → no stall.
- **Load-use, 3 cycles:** `LOAD_USE_CYCLES` = 3 → `ctrl_state` 0 → 1 → 1 → 0; 3 stall cycles.
  - `mem_branch_taken` pulsed in the second stall cycle → flush outputs that cycle, then RUN. `flush_count` = 1.
- **Memory wait:** `mem_req` = 1, `mem_ready` low 4 cycles then high → 4 freeze cycles with `memwb_bubble` = 1, `ctrl_state` = 2, then RUN; `stall_cycles` = 4.
  - Simultaneous `mem_branch_taken` is not flushed until the ready cycle.
- **Timeout:** `MEM_TIMEOUT` = 8 with `mem_ready` held low → HALT entered after 8 wait cycles; `mem_error` = 1 and all enables 0 until `rst`, which returns to RUN.
- **Saturation:** hold the memory stall for more than 65535 cycles (`MEM_TIMEOUT` = 65535, then HALT) → `stall_cycles` stops at 0xFFFF.
